// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard/stall controller.
package hazard_pkg;

  localparam int REG_W       = 3;
  localparam int CNT_W       = 3;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    LDUSE   = 3'd1,
    MEMWAIT = 3'd2,
    DRAIN   = 3'd3,
    HALTED  = 3'd4
  } state_t;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/hazard_ctrl_lu_detect.sv
// Load-use hazard comparator: the load in EX writes a register the ID instruction reads.
module lu_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic             rs_valid,
  input  logic [REG_W-1:0] rt,
  input  logic             rt_valid,
  input  logic             mem_read,
  input  logic [REG_W-1:0] write_reg,
  output logic             lu
);

  assign lu = mem_read & ((rs_valid & (rs == write_reg)) |
                          (rt_valid & (rt == write_reg)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flush, memory freeze, halt drain.
// Define STALL_CNT_EN to add the saturating stall_count output.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LU_BUBBLES = 1,
  parameter int HALT_DRAIN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_valid,
  input  logic             id_rt_valid,
  input  logic             id_halt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_branch_taken,
  input  logic             mem_stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             zero_control_signals,
  output logic             pipe_hold,
  output logic             halted
`ifdef STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_count
`endif
);

  state_t state, state_nxt;
  state_t ret, ret_nxt;
  state_t mode;
  cnt_t   cnt, cnt_nxt;
  logic   lu;

  lu_detect u_lu_detect (
    .rs        (id_rs),
    .rs_valid  (id_rs_valid),
    .rt        (id_rt),
    .rt_valid  (id_rt_valid),
    .mem_read  (ex_mem_read),
    .write_reg (ex_write_reg),
    .lu        (lu)
  );

  // After a memory freeze the machine resumes with the rules of the saved state.
  assign mode = (state == MEMWAIT) ? ret : state;

  always_comb begin
    // NOTE: every output and next-state value gets a default before any branch,
    // so no path leaves a variable unassigned and no latch is inferred.
    state_nxt            = state;
    ret_nxt              = ret;
    cnt_nxt              = cnt;
    pc_write             = 1'b1;
    ifid_write           = 1'b1;
    ifid_flush           = 1'b0;
    zero_control_signals = 1'b0;
    pipe_hold            = 1'b0;
    halted               = 1'b0;

    if (state == HALTED) begin
      halted               = 1'b1;
      pc_write             = 1'b0;
      ifid_write           = 1'b0;
      zero_control_signals = 1'b1;
    end else if (mem_stall) begin
      pipe_hold  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_nxt  = MEMWAIT;
      if (state != MEMWAIT) ret_nxt = state;
    end else begin
      state_nxt = mode;
      unique case (mode)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush           = 1'b1;
            zero_control_signals = 1'b1;
          end else if (lu) begin
            pc_write             = 1'b0;
            ifid_write           = 1'b0;
            zero_control_signals = 1'b1;
            if (LU_BUBBLES > 1) begin
              cnt_nxt   = cnt_t'(LU_BUBBLES - 1);
              state_nxt = LDUSE;
            end
          end else if (id_halt) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            cnt_nxt    = cnt_t'(HALT_DRAIN);
            state_nxt  = DRAIN;
          end
        end
        LDUSE, DRAIN: begin
          if (ex_branch_taken) begin
            // Younger instructions are on the wrong path; flush and resume fetching.
            ifid_flush           = 1'b1;
            zero_control_signals = 1'b1;
            cnt_nxt              = '0;
            state_nxt            = RUN;
          end else begin
            pc_write             = 1'b0;
            ifid_write           = 1'b0;
            zero_control_signals = 1'b1;
            cnt_nxt              = cnt - cnt_t'(1);
            if (cnt == cnt_t'(1)) state_nxt = (mode == DRAIN) ? HALTED : RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end

    if (!rst) begin
      pc_write             = 1'b1;
      ifid_write           = 1'b1;
      ifid_flush           = 1'b0;
      zero_control_signals = 1'b0;
      pipe_hold            = 1'b0;
      halted               = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      ret   <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ret   <= ret_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (!pc_write && (state != HALTED) && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (LU_BUBBLES=2, HALT_DRAIN=3).
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] id_rs = '0, id_rt = '0, ex_write_reg = '0;
  logic       id_rs_valid = 1'b0, id_rt_valid = 1'b0, id_halt = 1'b0;
  logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_stall = 1'b0;
  logic       pc_write, ifid_write, ifid_flush, zero_control_signals, pipe_hold, halted;
`ifdef STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  hazard_ctrl #(.LU_BUBBLES(2), .HALT_DRAIN(3)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .id_rs                (id_rs),
    .id_rt                (id_rt),
    .id_rs_valid          (id_rs_valid),
    .id_rt_valid          (id_rt_valid),
    .id_halt              (id_halt),
    .ex_mem_read          (ex_mem_read),
    .ex_write_reg         (ex_write_reg),
    .ex_branch_taken      (ex_branch_taken),
    .mem_stall            (mem_stall),
    .pc_write             (pc_write),
    .ifid_write           (ifid_write),
    .ifid_flush           (ifid_flush),
    .zero_control_signals (zero_control_signals),
    .pipe_hold            (pipe_hold),
    .halted               (halted)
`ifdef STALL_CNT_EN
    ,
    .stall_count          (stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] rs;
    logic       rs_v;
    logic [2:0] rt;
    logic       rt_v;
    logic       mrd;
    logic [2:0] wr;
    logic       halt;
    logic       br;
    logic       stall;
  } stim_t;

  // {pc_write, ifid_write, ifid_flush, zero_control_signals, pipe_hold, halted}
  typedef logic [5:0] out_t;
  localparam out_t O_RUN    = 6'b110000;
  localparam out_t O_BUB    = 6'b000100;
  localparam out_t O_BR     = 6'b111100;
  localparam out_t O_HOLD   = 6'b000010;
  localparam out_t O_HID    = 6'b000000;
  localparam out_t O_HALTED = 6'b000101;

  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];

  function automatic stim_t mk(logic [2:0] rs, logic rs_v, logic [2:0] rt, logic rt_v,
                               logic mrd, logic [2:0] wr, logic halt, logic br, logic stall);
    stim_t s;
    s.rs = rs; s.rs_v = rs_v; s.rt = rt; s.rt_v = rt_v; s.mrd = mrd; s.wr = wr;
    s.halt = halt; s.br = br; s.stall = stall;
    return s;
  endfunction

  stim_t IDLE, LU_RS, LU_RT, NOLU_INV, NOLU_NOLD, BR, STALL, HALT;

  function automatic out_t obs();
    return {pc_write, ifid_write, ifid_flush, zero_control_signals, pipe_hold, halted};
  endfunction

  task automatic apply(stim_t s, out_t e);
    id_rs = s.rs; id_rs_valid = s.rs_v; id_rt = s.rt; id_rt_valid = s.rt_v;
    ex_mem_read = s.mrd; ex_write_reg = s.wr; id_halt = s.halt;
    ex_branch_taken = s.br; mem_stall = s.stall;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    apply(IDLE, O_RUN);
    void'(exp_q.pop_front());
    rst = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    out_t got;
    apply(HALT, O_RUN);
    id_rs = 3'd3; id_rs_valid = 1'b1; ex_mem_read = 1'b1; ex_write_reg = 3'd3;
    #1;
    got = obs(); checks++;
    if (got !== exp_q.pop_front()) begin
      errors++; $display("FAIL reset_hold: got %b expected %b", got, O_RUN);
    end
`ifdef STALL_CNT_EN
    checks++;
    if (stall_count !== 16'd0) begin
      errors++; $display("FAIL reset_stall_count: got %0d expected 0", stall_count);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    apply(IDLE, O_RUN);
    @(negedge clk);
    got = obs(); checks++;
    if (got !== exp_q.pop_front()) begin
      errors++; $display("FAIL reset_release: got %b expected %b", got, O_RUN);
    end
    @(posedge clk); #1;
  endtask

  // Runs a stimulus table against expected outputs, one clock per entry.
  `define RUN_TABLE(NAME) \
    foreach (s[i]) begin \
      out_t got, e; \
      apply(s[i], x[i]); \
      @(negedge clk); \
      e = exp_q.pop_front(); got = obs(); checks++; \
      if (got !== e) begin \
        errors++; $display("FAIL %s[%0d]: got %b expected %b", NAME, i, got, e); \
      end \
      @(posedge clk); #1; \
    end

  task automatic test_load_use();
    stim_t s[$]; out_t x[$];
    do_reset();
    s = '{LU_RS, IDLE, IDLE, LU_RT, LU_RT, IDLE, NOLU_INV, NOLU_NOLD};
    x = '{O_BUB, O_BUB, O_RUN, O_BUB, O_BUB, O_RUN, O_RUN,    O_RUN};
    `RUN_TABLE("load_use")
  endtask

  task automatic test_branch_vs_lu();
    stim_t s[$]; out_t x[$]; stim_t br_lu, br_halt;
    br_lu = LU_RS; br_lu.br = 1'b1;
    br_halt = HALT; br_halt.br = 1'b1;
    do_reset();
    s = '{br_lu, IDLE,  BR,   IDLE,  LU_RS, BR,   IDLE,  br_halt, IDLE};
    x = '{O_BR,  O_RUN, O_BR, O_RUN, O_BUB, O_BR, O_RUN, O_BR,    O_RUN};
    `RUN_TABLE("branch_vs_lu")
  endtask

  task automatic test_mem_stall();
    stim_t s[$]; out_t x[$]; stim_t st_lu;
    st_lu = LU_RS; st_lu.stall = 1'b1;
    do_reset();
    s = '{LU_RS, STALL,  STALL,  STALL,  STALL,  IDLE,  IDLE,
          st_lu, LU_RS, IDLE,  IDLE};
    x = '{O_BUB, O_HOLD, O_HOLD, O_HOLD, O_HOLD, O_BUB, O_RUN,
          O_HOLD, O_BUB, O_BUB, O_RUN};
    `RUN_TABLE("mem_stall")
  endtask

  task automatic test_halt();
    stim_t s[$]; out_t x[$];
    do_reset();
    s = '{HALT,  HALT,  HALT,  HALT,  IDLE,     STALL,    BR,       LU_RS};
    x = '{O_HID, O_BUB, O_BUB, O_BUB, O_HALTED, O_HALTED, O_HALTED, O_HALTED};
    `RUN_TABLE("halt")
  endtask

  task automatic test_branch_in_drain();
    stim_t s[$]; out_t x[$];
    do_reset();
    s = '{HALT,  HALT,  BR,   IDLE,  IDLE,  LU_RS, IDLE,  IDLE};
    x = '{O_HID, O_BUB, O_BR, O_RUN, O_RUN, O_BUB, O_BUB, O_RUN};
    `RUN_TABLE("branch_in_drain")
  endtask

  task automatic test_back_to_back();
    stim_t s[$]; out_t x[$]; stim_t lu_halt;
    lu_halt = LU_RS; lu_halt.halt = 1'b1;
    do_reset();
    s = '{lu_halt, IDLE,  HALT,  IDLE,  STALL,  STALL,  IDLE,  IDLE,  IDLE,  IDLE};
    x = '{O_BUB,   O_BUB, O_HID, O_BUB, O_HOLD, O_HOLD, O_BUB, O_BUB, O_HALTED, O_HALTED};
    `RUN_TABLE("back_to_back")
  endtask

  task automatic test_reset_mid_drain();
    stim_t s[$]; out_t x[$]; out_t got;
    do_reset();
    s = '{HALT,  HALT};
    x = '{O_HID, O_BUB};
    `RUN_TABLE("mid_drain_setup")
    apply(HALT, O_RUN);
    rst = 1'b0;
    #1;
    got = obs(); checks++;
    if (got !== exp_q.pop_front()) begin
      errors++; $display("FAIL mid_drain_reset: got %b expected %b", got, O_RUN);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    s = '{IDLE,  HALT,  HALT};
    x = '{O_RUN, O_HID, O_BUB};
    `RUN_TABLE("after_mid_drain_reset")
  endtask

  task automatic test_stall_count();
`ifdef STALL_CNT_EN
    stim_t s[$]; out_t x[$];
    do_reset();
    s = '{LU_RS, IDLE,  STALL,  STALL,  STALL,  IDLE};
    x = '{O_BUB, O_BUB, O_HOLD, O_HOLD, O_HOLD, O_RUN};
    `RUN_TABLE("stall_count_seq")
    checks++;
    if (stall_count !== 16'd5) begin
      errors++; $display("FAIL stall_count: got %0d expected 5", stall_count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (stall_count !== 16'd0) begin
      errors++; $display("FAIL stall_count_reset: got %0d expected 0", stall_count);
    end
    rst = 1'b1;
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    IDLE      = mk(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    LU_RS     = mk(3'd3, 1'b1, 3'd1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    LU_RT     = mk(3'd5, 1'b0, 3'd5, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    NOLU_INV  = mk(3'd3, 1'b0, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    NOLU_NOLD = mk(3'd3, 1'b1, 3'd3, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    BR        = mk(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    STALL     = mk(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    HALT      = mk(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);

    #1;
    test_reset();
    test_load_use();
    test_branch_vs_lu();
    test_mem_stall();
    test_halt();
    test_branch_in_drain();
    test_back_to_back();
    test_reset_mid_drain();
    test_stall_count();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
